// File: rtl/frame_color_scanner_if.sv
// Processing-port bundle between the frame buffer and the colour scanner.
// The scanner drives the address and the frame buffer returns the pixel in the same cycle.
interface frame_color_scanner_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_data;

    modport master (output proc_addr, input proc_data);
    modport slave  (input proc_addr, output proc_data);
endinterface

// File: rtl/frame_color_scanner.sv
// Sweeps a stored RGB444 frame one pixel per clock, counts red/green/blue pixels
// and publishes the counts and the dominant colour.
module frame_color_scanner #(
    parameter int AW      = 15,
    parameter int DW      = 12,
    parameter int NPIX    = 19200,
    parameter int MIN_LVL = 4,
    parameter int MIN_CNT = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    frame_color_scanner_if.master        proc_if,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [1:0]                   color_o,
    output logic [AW-1:0]                red_cnt_o,
    output logic [AW-1:0]                green_cnt_o,
    output logic [AW-1:0]                blue_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW-1:0] CNT_MAX   = '1;
    localparam logic [AW-1:0] MIN_CNT_V = AW'(MIN_CNT);
    localparam logic [3:0]    MIN_LVL_V = 4'(MIN_LVL);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] redAcc_q, redAcc_d;
    logic [AW-1:0] greenAcc_q, greenAcc_d;
    logic [AW-1:0] blueAcc_q, blueAcc_d;
    logic [AW-1:0] redCnt_q, redCnt_d;
    logic [AW-1:0] greenCnt_q, greenCnt_d;
    logic [AW-1:0] blueCnt_q, blueCnt_d;
    logic [1:0]    color_q, color_d;
    logic          busy_q, done_q;

    logic [3:0]    pixR, pixG, pixB;
    logic          isRed, isGreen, isBlue;
    logic [AW-1:0] maxCnt;
    logic [1:0]    winColor;

    assign pixR = proc_if.proc_data[DW-1 -: 4];
    assign pixG = proc_if.proc_data[DW-5 -: 4];
    assign pixB = proc_if.proc_data[DW-9 -: 4];

    // Strict compares: a pixel whose two strongest channels are equal belongs to no class.
    assign isRed   = (pixR > pixG) && (pixR > pixB) && (pixR >= MIN_LVL_V);
    assign isGreen = (pixG > pixR) && (pixG > pixB) && (pixG >= MIN_LVL_V);
    assign isBlue  = (pixB > pixR) && (pixB > pixG) && (pixB >= MIN_LVL_V);

    // Only a strictly larger count displaces the current leader, so ties favour red, then green.
    always_comb begin
        maxCnt   = redAcc_q;
        winColor = 2'b01;
        if (greenAcc_q > maxCnt) begin
            maxCnt   = greenAcc_q;
            winColor = 2'b10;
        end
        if (blueAcc_q > maxCnt) begin
            maxCnt   = blueAcc_q;
            winColor = 2'b11;
        end
        if (maxCnt < MIN_CNT_V) begin
            winColor = 2'b00;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        redAcc_d   = redAcc_q;
        greenAcc_d = greenAcc_q;
        blueAcc_d  = blueAcc_q;
        redCnt_d   = redCnt_q;
        greenCnt_d = greenCnt_q;
        blueCnt_d  = blueCnt_q;
        color_d    = color_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    redAcc_d   = '0;
                    greenAcc_d = '0;
                    blueAcc_d  = '0;
                    addr_d     = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (isRed && (redAcc_q != CNT_MAX)) begin
                    redAcc_d = redAcc_q + AW'(1);
                end
                if (isGreen && (greenAcc_q != CNT_MAX)) begin
                    greenAcc_d = greenAcc_q + AW'(1);
                end
                if (isBlue && (blueAcc_q != CNT_MAX)) begin
                    blueAcc_d = blueAcc_q + AW'(1);
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = DECIDE;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            DECIDE: begin
                redCnt_d   = redAcc_q;
                greenCnt_d = greenAcc_q;
                blueCnt_d  = blueAcc_q;
                color_d    = winColor;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy and done trail the state by one edge, so done lands in the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            redAcc_q   <= '0;
            greenAcc_q <= '0;
            blueAcc_q  <= '0;
            redCnt_q   <= '0;
            greenCnt_q <= '0;
            blueCnt_q  <= '0;
            color_q    <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            redAcc_q   <= redAcc_d;
            greenAcc_q <= greenAcc_d;
            blueAcc_q  <= blueAcc_d;
            redCnt_q   <= redCnt_d;
            greenCnt_q <= greenCnt_d;
            blueCnt_q  <= blueCnt_d;
            color_q    <= color_d;
            busy_q     <= (state_q != IDLE);
            done_q     <= (state_q == DONE);
        end
    end

    assign proc_if.proc_addr = addr_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign color_o           = color_q;
    assign red_cnt_o         = redCnt_q;
    assign green_cnt_o       = greenCnt_q;
    assign blue_cnt_o        = blueCnt_q;

endmodule

// File: tb/tb_frame_color_scanner.sv
// Directed bench for frame_color_scanner on a reduced 1200-pixel frame,
// with hand-computed counts, colours and latencies.
module tb_frame_color_scanner;

    localparam int AW      = 15;
    localparam int DW      = 12;
    localparam int NPIX    = 1200;
    localparam int MIN_LVL = 4;
    localparam int MIN_CNT = 256;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    color_o;
    logic [AW-1:0] red_cnt_o;
    logic [AW-1:0] green_cnt_o;
    logic [AW-1:0] blue_cnt_o;

    logic [DW-1:0] frameMem [NPIX];

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;
    int maxAddr    = 0;

    frame_color_scanner_if #(.AW(AW), .DW(DW)) procBus ();

    frame_color_scanner #(
        .AW(AW), .DW(DW), .NPIX(NPIX), .MIN_LVL(MIN_LVL), .MIN_CNT(MIN_CNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_if    (procBus),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .color_o    (color_o),
        .red_cnt_o  (red_cnt_o),
        .green_cnt_o(green_cnt_o),
        .blue_cnt_o (blue_cnt_o)
    );

    always #5 clk = ~clk;

    // The frame buffer read is combinational on the address.
    assign procBus.proc_data = (int'(procBus.proc_addr) < NPIX) ? frameMem[int'(procBus.proc_addr)] : '0;

    always @(negedge clk) begin
        if (done_o === 1'b1) doneCount++;
        if (int'(procBus.proc_addr) > maxAddr) maxAddr = int'(procBus.proc_addr);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic fillRange(input int lo, input int hi, input logic [DW-1:0] px);
        for (int i = lo; i <= hi; i++) frameMem[i] = px;
    endtask

    // Pulses start, then counts edges until done; optionally fires ignored start pulses mid-run.
    task automatic applyStimulus(input bit pulseDuring, output int cycles);
        @(negedge clk) start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        cycles = 0;
        while (done_o !== 1'b1 && cycles < NPIX + 50) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) checkOutput("busyRise", busy_o, 1);
            start_i = pulseDuring && ((cycles % 300 == 0) || (cycles == NPIX + 1));
        end
        start_i = 1'b0;
    endtask

    task automatic runSweep(input string tag, input int expRed, input int expGreen,
                            input int expBlue, input int expColor, input bit pulseDuring);
        int cycles;
        applyStimulus(pulseDuring, cycles);
        checkOutput({tag, "_latency"}, cycles, NPIX + 2);
        checkOutput({tag, "_busyAtDone"}, busy_o, 1);
        checkOutput({tag, "_red"}, red_cnt_o, expRed);
        checkOutput({tag, "_green"}, green_cnt_o, expGreen);
        checkOutput({tag, "_blue"}, blue_cnt_o, expBlue);
        checkOutput({tag, "_color"}, color_o, expColor);
        @(posedge clk);
        #1;
        checkOutput({tag, "_doneFall"}, done_o, 0);
        checkOutput({tag, "_busyFall"}, busy_o, 0);
    endtask

    initial begin
        int n;
        int doneBase;
        int first;
        int second;

        fillRange(0, NPIX - 1, 12'h000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_color", color_o, 0);
        checkOutput("rst_red", red_cnt_o, 0);
        checkOutput("rst_green", green_cnt_o, 0);
        checkOutput("rst_blue", blue_cnt_o, 0);
        checkOutput("rst_addr", procBus.proc_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] all-red frame");
        fillRange(0, NPIX - 1, 12'hF00);
        runSweep("allRed", 1200, 0, 0, 1, 1'b0);

        $display("[TB] blue majority over green");
        fillRange(0, 649, 12'h00F);
        fillRange(650, NPIX - 1, 12'h0F0);
        runSweep("blueMaj", 0, 550, 650, 3, 1'b0);

        $display("[TB] red/green tie");
        fillRange(0, 599, 12'hF00);
        fillRange(600, NPIX - 1, 12'h0F0);
        runSweep("tieRG", 600, 600, 0, 1, 1'b0);

        $display("[TB] equal top channels");
        fillRange(0, NPIX - 1, 12'hFF0);
        fillRange(0, 299, 12'h0F0);
        fillRange(300, 399, 12'h0FF);
        fillRange(400, 409, 12'hF0F);
        fillRange(410, 419, 12'h454);
        runSweep("eqTop", 0, 310, 0, 2, 1'b0);

        $display("[TB] below minimum level");
        fillRange(0, NPIX - 1, 12'h333);
        runSweep("lowLvl", 0, 0, 0, 0, 1'b0);

        $display("[TB] red below minimum count");
        fillRange(0, NPIX - 1, 12'h000);
        fillRange(0, 149, 12'hF00);
        fillRange(150, 199, 12'h400);
        fillRange(200, 249, 12'h300);
        runSweep("lowCnt", 200, 0, 0, 0, 1'b0);

        $display("[TB] count boundary 255 and 256");
        fillRange(0, NPIX - 1, 12'h000);
        fillRange(0, 254, 12'h400);
        runSweep("cnt255", 255, 0, 0, 0, 1'b0);
        fillRange(255, 255, 12'h400);
        fillRange(256, 299, 12'h040);
        runSweep("cnt256", 256, 44, 0, 1, 1'b0);

        $display("[TB] reset mid-sweep");
        fillRange(0, NPIX - 1, 12'h0F0);
        @(negedge clk) start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        while (int'(procBus.proc_addr) != 500 && n < NPIX) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("midRst_reach", procBus.proc_addr, 500);
        doneBase = doneCount;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_busy", busy_o, 0);
        checkOutput("midRst_red", red_cnt_o, 0);
        checkOutput("midRst_green", green_cnt_o, 0);
        checkOutput("midRst_color", color_o, 0);
        checkOutput("midRst_addr", procBus.proc_addr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (NPIX + 20) @(posedge clk);
        #1;
        checkOutput("midRst_noDone", doneCount - doneBase, 0);
        runSweep("afterRst", 0, 1200, 0, 2, 1'b0);

        $display("[TB] start pulses while busy");
        fillRange(0, 399, 12'h00F);
        fillRange(400, NPIX - 1, 12'hF00);
        doneBase = doneCount;
        maxAddr = 0;
        runSweep("busyStart", 800, 0, 400, 1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("busyStart_oneDone", doneCount - doneBase, 1);
        checkOutput("busyStart_idle", busy_o, 0);
        checkOutput("busyStart_maxAddr", maxAddr, NPIX - 1);
        checkOutput("busyStart_addrHold", procBus.proc_addr, NPIX - 1);

        $display("[TB] start held high across done");
        fillRange(0, NPIX - 1, 12'h00F);
        @(negedge clk) start_i = 1'b1;
        n = 0;
        first = -1;
        second = -1;
        while (second < 0 && n < 3 * NPIX) begin
            @(posedge clk);
            #1;
            n++;
            if (done_o === 1'b1) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        start_i = 1'b0;
        checkOutput("held_gap", second - first, NPIX + 3);
        checkOutput("held_blue", blue_cnt_o, 1200);
        checkOutput("held_color", color_o, 3);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("held_stop", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
